// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard / stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } state_e;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 15;
  localparam int REM_W        = 4;

endpackage

// File: rtl/reg_match.sv
// Register-address comparator; register 0 is hardwired and never matches.
module reg_match #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  output logic          match
);

  assign match = (src_a == src_b) && (src_a != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection and pipeline stall/flush control with stall-cycle counter.
// Optional macro HAZARD_BRANCH_FLUSH_EN: taken branch in EX flushes IF/ID and ID/EX and aborts stalls.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              ext_stall_req,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              stall_sel,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [PERF_W-1:0] stall_cycles
);

  if ((LOAD_LAT < LOAD_LAT_MIN) || (LOAD_LAT > LOAD_LAT_MAX)) begin : g_bad_load_lat
    $error("hazard_stall_ctrl: LOAD_LAT out of range 1..15");
  end

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic              rs_match, rt_match, hit, branch_flush;

  reg_match #(.AW(REG_AW)) u_rs_match (
    .src_a (id_ex_rt),
    .src_b (if_id_rs),
    .match (rs_match)
  );

  reg_match #(.AW(REG_AW)) u_rt_match (
    .src_a (id_ex_rt),
    .src_b (if_id_rt),
    .match (rt_match)
  );

  assign hit = id_ex_memread && (rs_match || (if_id_uses_rt && rt_match));

`ifdef HAZARD_BRANCH_FLUSH_EN
  assign branch_flush = ex_branch_taken;
`else
  logic unused_branch;
  assign unused_branch = ex_branch_taken;
  assign branch_flush  = 1'b0;
`endif

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path leaves it unassigned (no latches).
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    stall_sel   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = state_q;
    rem_d       = rem_q;

    if (branch_flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = RUN;
      rem_d       = '0;
    end else if (ext_stall_req) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall_sel   = 1'b0;
    end else if (state_q == LSTALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall_sel   = 1'b0;
      rem_d       = rem_q - REM_W'(1);
      if (rem_q == REM_W'(1)) begin
        state_d = RUN;
        rem_d   = '0;
      end
    end else if (hit) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall_sel   = 1'b0;
      // The hit cycle itself is the first stall cycle; LSTALL covers the rest.
      if (LOAD_LAT > 1) begin
        state_d = LSTALL;
        rem_d   = REM_W'(LOAD_LAT - 1);
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != {PERF_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      rem_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: LOAD_LAT=1 and LOAD_LAT=3 instances driven in parallel against a stall-budget model.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_BRANCH_FLUSH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       if_id_uses_rt, ext_stall_req, ex_branch_taken;

  logic        pc1, ifw1, sel1, iff1, exf1;
  logic [15:0] cnt1;
  logic        pc3, ifw3, sel3, iff3, exf3;
  logic [3:0]  cnt3;

  int vectors = 0;
  int fails   = 0;

  // Model state per instance: index 0 = LOAD_LAT 1, index 1 = LOAD_LAT 3.
  int lat     [2] = '{1, 3};
  int cmax    [2] = '{65535, 15};
  int left    [2];
  int cnt     [2];
  logic cap_pc[2];
  logic cap_fl[2];
  int cap_cnt [2];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ext_stall_req(ext_stall_req), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc1), .if_id_write(ifw1), .stall_sel(sel1),
    .if_id_flush(iff1), .id_ex_flush(exf1), .stall_cycles(cnt1)
  );

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(4)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ext_stall_req(ext_stall_req), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc3), .if_id_write(ifw3), .stall_sel(sel3),
    .if_id_flush(iff3), .id_ex_flush(exf3), .stall_cycles(cnt3)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic ext, input logic br);
    id_ex_memread   = mr;
    id_ex_rt        = ert;
    if_id_rs        = rs;
    if_id_rt        = rt;
    if_id_uses_rt   = ur;
    ext_stall_req   = ext;
    ex_branch_taken = br;
  endtask

  task automatic check_dut(input int d, input string tag, input logic exp_pc,
                           input logic exp_fl, input int exp_cnt);
    if (d == 0) begin
      check({tag, ".lat1.pc_write"},    int'(pc1),  int'(exp_pc));
      check({tag, ".lat1.if_id_write"}, int'(ifw1), int'(exp_pc));
      check({tag, ".lat1.stall_sel"},   int'(sel1), int'(exp_pc));
      check({tag, ".lat1.if_id_flush"}, int'(iff1), int'(exp_fl));
      check({tag, ".lat1.id_ex_flush"}, int'(exf1), int'(exp_fl));
      check({tag, ".lat1.stall_cycles"}, int'(cnt1), exp_cnt);
    end else begin
      check({tag, ".lat3.pc_write"},    int'(pc3),  int'(exp_pc));
      check({tag, ".lat3.if_id_write"}, int'(ifw3), int'(exp_pc));
      check({tag, ".lat3.stall_sel"},   int'(sel3), int'(exp_pc));
      check({tag, ".lat3.if_id_flush"}, int'(iff3), int'(exp_fl));
      check({tag, ".lat3.id_ex_flush"}, int'(exf3), int'(exp_fl));
      check({tag, ".lat3.stall_cycles"}, int'(cnt3), exp_cnt);
    end
  endtask

  // One clock cycle: drive, compare both instances against the model, then advance the model on the edge.
  task automatic apply(input string tag, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic ext, input logic br);
    logic hit;
    logic exp_pc, exp_fl;
    int   nleft [2];
    int   ncnt  [2];
    @(negedge clk);
    drive(mr, ert, rs, rt, ur, ext, br);
    #1;
    hit = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
    for (int d = 0; d < 2; d++) begin
      nleft[d] = left[d];
      if (BR_EN && br) begin
        exp_pc = 1'b1; exp_fl = 1'b1; nleft[d] = 0;
      end else if (ext) begin
        exp_pc = 1'b0; exp_fl = 1'b0;
      end else if (left[d] > 0) begin
        exp_pc = 1'b0; exp_fl = 1'b0; nleft[d] = left[d] - 1;
      end else if (hit) begin
        exp_pc = 1'b0; exp_fl = 1'b0; nleft[d] = lat[d] - 1;
      end else begin
        exp_pc = 1'b1; exp_fl = 1'b0;
      end
      ncnt[d] = (!exp_pc && cnt[d] < cmax[d]) ? cnt[d] + 1 : cnt[d];
      check_dut(d, tag, exp_pc, exp_fl, cnt[d]);
      cap_pc[d]  = (d == 0) ? pc1 : pc3;
      cap_fl[d]  = (d == 0) ? iff1 : iff3;
      cap_cnt[d] = (d == 0) ? int'(cnt1) : int'(cnt3);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      left[d] = nleft[d];
      cnt[d]  = ncnt[d];
    end
  endtask

  task automatic idle(input string tag);
    apply(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hit_once(input string tag);
    apply(tag, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and checks outputs respond before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check_dut(d, tag, 1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      left[d] = 0;
      cnt[d]  = 0;
    end
  endtask

  typedef struct {
    logic       mr;
    logic [4:0] ert, rs, rt;
    logic       ur, ext;
    logic       exp_run;
  } vec_t;

  vec_t tbl [10];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      left[d] = 0;
      cnt[d]  = 0;
    end
    #3;
    for (int d = 0; d < 2; d++) check_dut(d, "reset_state", 1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: expectations are for the LOAD_LAT=1 instance, which carries no stall state between vectors.
    tbl[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 5'd31, 5'd30, 5'd31, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 5'd0,  5'd1,  5'd0,  1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 5'd9,  5'd8,  5'd10, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      apply("table", tbl[i].mr, tbl[i].ert, tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].ext, 1'b0);
      check($sformatf("table[%0d].lat1.pc_write", i), int'(cap_pc[0]), int'(tbl[i].exp_run));
    end

    // Single-cycle load-use stall with LOAD_LAT=1.
    do_reset("rst_a");
    hit_once("lat1_hit");
    check("lat1_hit.pc", int'(cap_pc[0]), 0);
    idle("lat1_after");
    check("lat1_after.pc", int'(cap_pc[0]), 1);
    check("lat1_after.cnt", cap_cnt[0], 1);

    // LOAD_LAT=3: exactly three stall cycles.
    do_reset("rst_b");
    hit_once("lat3_s1");
    check("lat3_s1.pc", int'(cap_pc[1]), 0);
    idle("lat3_s2");
    check("lat3_s2.pc", int'(cap_pc[1]), 0);
    idle("lat3_s3");
    check("lat3_s3.pc", int'(cap_pc[1]), 0);
    idle("lat3_run");
    check("lat3_run.pc", int'(cap_pc[1]), 1);
    check("lat3_run.cnt", cap_cnt[1], 3);

    // External freeze during LSTALL stretches the stall to five cycles.
    do_reset("rst_c");
    hit_once("frz_s1");
    idle("frz_s2");
    apply("frz_x1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    apply("frz_x2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle("frz_s3");
    check("frz_s3.pc", int'(cap_pc[1]), 0);
    idle("frz_run");
    check("frz_run.pc", int'(cap_pc[1]), 1);
    check("frz_run.cnt", cap_cnt[1], 5);

    // Taken branch in the second LSTALL cycle.
    do_reset("rst_d");
    hit_once("br_s1");
    apply("br_s2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("br_s2.pc", int'(cap_pc[1]), BR_EN ? 1 : 0);
    check("br_s2.flush", int'(cap_fl[1]), BR_EN ? 1 : 0);
    idle("br_s3");
    check("br_s3.pc", int'(cap_pc[1]), BR_EN ? 1 : 0);
    check("br_s3.flush", int'(cap_fl[1]), 0);
    idle("br_s4");

    // Counter saturation (LOAD_LAT=3 instance has a 4-bit counter), then reset mid-LSTALL.
    do_reset("rst_e");
    for (int i = 0; i < 19; i++) apply("sat", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle("sat_done");
    check("sat_done.lat3_cnt", cap_cnt[1], 15);
    check("sat_done.lat1_cnt", cap_cnt[0], 19);
    hit_once("abort_s1");
    idle("abort_s2");
    check("abort_s2.pc", int'(cap_pc[1]), 0);
    do_reset("abort_rst");
    idle("abort_run");
    check("abort_run.pc", int'(cap_pc[1]), 1);

    // Randomized traffic on a small register set so hits are frequent.
    do_reset("rst_f");
    for (int i = 0; i < 400; i++) begin
      apply("rand",
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
